// File: rtl/rfsh_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : rfsh_fetch
//  Purpose  : Multi-channel byte streamer that reads SDRAM only inside Z80
//             refresh slots, with per-channel FWFT FIFOs and round-robin grant.
//  Revision : 1.0 - initial release
// ============================================================================
module rfsh_fetch #(
    parameter int CHANNELS  = 2,
    parameter int ADDR_W    = 25,
    parameter int DEPTH     = 4,
    parameter int ACK_DELAY = 7
) (
    input  logic                       clk_sys,
    input  logic                       nRESET,
    input  logic                       nRFSH,
    input  logic [CHANNELS-1:0]        ch_start,
    input  logic [CHANNELS*ADDR_W-1:0] ch_base,
    input  logic [CHANNELS*ADDR_W-1:0] ch_len,
    input  logic [CHANNELS-1:0]        ch_rd,
    output logic [CHANNELS*8-1:0]      ch_dout,
    output logic [CHANNELS-1:0]        ch_empty,
    output logic [CHANNELS-1:0]        ch_busy,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic                       mem_rd,
    input  logic [7:0]                 mem_din
);
    localparam int c_GW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam int c_TW = $clog2(ACK_DELAY);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_FETCH = 1'b1;

    logic [0:0]        r_state, w_state_nxt;
    logic              r_nrfsh_q;
    logic [c_GW-1:0]   r_grant, r_rr, w_sel, w_idx;
    logic [c_TW-1:0]   r_tick;
    logic [ADDR_W-1:0] r_addr;

    logic [ADDR_W-1:0] r_ptr   [CHANNELS];
    logic [ADDR_W-1:0] r_rem   [CHANNELS];
    logic [c_CW-1:0]   r_count [CHANNELS];
    logic [c_PW-1:0]   r_rdp   [CHANNELS];
    logic [c_PW-1:0]   r_wrp   [CHANNELS];
    logic [7:0]        r_fifo  [CHANNELS][DEPTH];

    logic [CHANNELS-1:0] w_elig, w_push, w_pop, w_inflight;
    logic w_slot, w_any, w_launch, w_capture, w_kill;

    assign w_slot    = r_nrfsh_q & ~nRFSH;
    assign w_kill    = ch_start[r_grant];
    assign w_launch  = (r_state == S_IDLE) && w_slot && w_any;
    assign w_capture = (r_state == S_FETCH) && !w_kill && !nRFSH && (r_tick == c_TW'(1));

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            assign w_inflight[i] = (r_state == S_FETCH) && (r_grant == c_GW'(i));
            // A channel restarting this cycle is not granted; its pointer is being reloaded.
            assign w_elig[i] = (r_rem[i] != '0) && !ch_start[i] &&
                               (w_inflight[i] ? (r_count[i] < c_CW'(DEPTH - 1))
                                              : (r_count[i] < c_CW'(DEPTH)));
            assign w_push[i]   = w_capture && (r_grant == c_GW'(i));
            assign w_pop[i]    = ch_rd[i] && (r_count[i] != '0);
            assign ch_empty[i] = (r_count[i] == '0);
            assign ch_busy[i]  = (r_rem[i] != '0) || (r_count[i] != '0);
            assign ch_dout[i*8 +: 8] = (r_count[i] != '0) ? r_fifo[i][r_rdp[i]] : 8'h00;
        end
    endgenerate

    // Round-robin search: first eligible channel at or above r_rr, wrapping.
    always_comb begin
        w_sel = '0;
        w_idx = '0;
        w_any = 1'b0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            w_idx = c_GW'((int'(r_rr) + k) % CHANNELS);
            if (w_elig[w_idx]) begin
                w_any = 1'b1;
                w_sel = w_idx;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_launch) w_state_nxt = S_FETCH;
            S_FETCH: if (w_kill || nRFSH || (r_tick == c_TW'(1))) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mem_rd   = (r_state == S_FETCH);
        mem_addr = r_addr;
    end

    // r_tick counts edges left until capture: capture lands ACK_DELAY-1 cycles after mem_rd rises.
    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) begin
            r_nrfsh_q <= 1'b1;
            r_grant   <= '0;
            r_rr      <= '0;
            r_tick    <= '0;
            r_addr    <= '0;
        end else begin
            r_nrfsh_q <= nRFSH;
            if (w_launch) begin
                r_grant <= w_sel;
                r_addr  <= r_ptr[w_sel];
                r_tick  <= c_TW'(ACK_DELAY - 1);
            end else if ((r_state == S_FETCH) && (r_tick != c_TW'(1))) begin
                r_tick <= r_tick - 1'b1;
            end
            if (w_capture)
                r_rr <= (r_grant == c_GW'(CHANNELS - 1)) ? '0 : r_grant + 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_ptr[i]   <= '0;
                r_rem[i]   <= '0;
                r_count[i] <= '0;
                r_rdp[i]   <= '0;
                r_wrp[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (ch_start[i]) begin
                    r_ptr[i]   <= ch_base[i*ADDR_W +: ADDR_W];
                    r_rem[i]   <= ch_len[i*ADDR_W +: ADDR_W];
                    r_count[i] <= '0;
                    r_rdp[i]   <= '0;
                    r_wrp[i]   <= '0;
                end else begin
                    if (w_push[i]) begin
                        r_wrp[i] <= r_wrp[i] + 1'b1;
                        r_ptr[i] <= r_ptr[i] + 1'b1;
                        r_rem[i] <= r_rem[i] - 1'b1;
                    end
                    if (w_pop[i])
                        r_rdp[i] <= r_rdp[i] + 1'b1;
                    if (w_push[i] && !w_pop[i])
                        r_count[i] <= r_count[i] + 1'b1;
                    else if (!w_push[i] && w_pop[i])
                        r_count[i] <= r_count[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        for (int i = 0; i < CHANNELS; i++)
            if (w_push[i])
                r_fifo[i][r_wrp[i]] <= mem_din;
    end

endmodule
`default_nettype wire

// File: tb/tb_rfsh_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rfsh_fetch
//  Purpose  : Randomized self-checking bench for rfsh_fetch against a
//             queue-based reference model of the refresh-slot streamer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rfsh_fetch;
    localparam int CH = 2;
    localparam int AW = 25;
    localparam int DP = 4;
    localparam int AD = 7;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic              nRESET, nRFSH;
    logic [CH-1:0]     ch_start, ch_rd;
    logic [CH*AW-1:0]  ch_base, ch_len;
    logic [CH*8-1:0]   ch_dout;
    logic [CH-1:0]     ch_empty, ch_busy;
    logic [AW-1:0]     mem_addr;
    logic              mem_rd;
    logic [7:0]        mem_din;

    function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
        return a[7:0] ^ a[23:16];
    endfunction

    assign mem_din = mem_byte(mem_addr);

    rfsh_fetch #(.CHANNELS(CH), .ADDR_W(AW), .DEPTH(DP), .ACK_DELAY(AD)) dut (
        .clk_sys(clk_sys), .nRESET(nRESET), .nRFSH(nRFSH),
        .ch_start(ch_start), .ch_base(ch_base), .ch_len(ch_len), .ch_rd(ch_rd),
        .ch_dout(ch_dout), .ch_empty(ch_empty), .ch_busy(ch_busy),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_din(mem_din)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: per-channel pointer/remaining and a byte queue per FIFO.
    logic [AW-1:0] m_ptr [CH];
    logic [AW-1:0] m_rem [CH];
    logic [7:0]    m_q   [CH][$];
    bit            m_busy, m_prev;
    int            m_grant, m_age, m_rr;
    logic [AW-1:0] m_addr;

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_ptr[i] = '0;
            m_rem[i] = '0;
            m_q[i].delete();
        end
        m_busy = 0; m_prev = 1; m_grant = 0; m_age = 0; m_rr = 0; m_addr = '0;
    endtask

    task automatic model_edge();
        bit slot;
        bit popf [CH];
        int sel;
        slot   = m_prev && !nRFSH;
        m_prev = nRFSH;
        for (int i = 0; i < CH; i++) popf[i] = ch_rd[i] && (m_q[i].size() > 0);
        if (m_busy) begin
            m_age++;
            if (ch_start[m_grant] || nRFSH) begin
                m_busy = 0;
            end else if (m_age == AD - 1) begin
                m_q[m_grant].push_back(mem_byte(m_addr));
                m_ptr[m_grant] = m_ptr[m_grant] + 1'b1;
                m_rem[m_grant] = m_rem[m_grant] - 1'b1;
                m_rr = (m_grant + 1) % CH;
                m_busy = 0;
            end
        end else if (slot) begin
            sel = -1;
            for (int k = 0; k < CH; k++) begin
                int c;
                c = (m_rr + k) % CH;
                if (sel < 0 && m_rem[c] != 0 && m_q[c].size() < DP && !ch_start[c]) sel = c;
            end
            if (sel >= 0) begin
                m_busy = 1; m_grant = sel; m_addr = m_ptr[sel]; m_age = 0;
            end
        end
        for (int i = 0; i < CH; i++) begin
            if (ch_start[i]) begin
                m_ptr[i] = ch_base[i*AW +: AW];
                m_rem[i] = ch_len[i*AW +: AW];
                m_q[i].delete();
            end else if (popf[i]) begin
                void'(m_q[i].pop_front());
            end
        end
    endtask

    task automatic check_all();
        chk("mem_rd", {63'd0, mem_rd}, {63'd0, m_busy});
        if (m_busy) chk("mem_addr", {39'd0, mem_addr}, {39'd0, m_addr});
        for (int i = 0; i < CH; i++) begin
            chk($sformatf("ch%0d_empty", i), {63'd0, ch_empty[i]}, {63'd0, m_q[i].size() == 0});
            chk($sformatf("ch%0d_busy", i), {63'd0, ch_busy[i]},
                {63'd0, (m_rem[i] != 0) || (m_q[i].size() != 0)});
            if (m_q[i].size() > 0)
                chk($sformatf("ch%0d_dout", i), {56'd0, ch_dout[i*8 +: 8]}, {56'd0, m_q[i][0]});
        end
    endtask

    task automatic cycle(input bit nr, input logic [CH-1:0] st, input logic [CH-1:0] rd);
        nRFSH = nr; ch_start = st; ch_rd = rd;
        @(posedge clk_sys);
        model_edge();
        #1;
        check_all();
    endtask

    // Random inputs for one cycle; starts never coincide with a slot-start edge.
    task automatic rand_cycle(input bit nr, input int pop_mode);
        logic [CH-1:0] st, rd;
        st = '0;
        rd = '0;
        for (int i = 0; i < CH; i++) begin
            if ($urandom_range(3) == 0)
                ch_base[i*AW +: AW] = {AW{1'b1}} - AW'($urandom_range(1));
            else
                ch_base[i*AW +: AW] = AW'($urandom);
            ch_len[i*AW +: AW] = AW'($urandom_range(12));
            if (pop_mode == 1) rd[i] = ($urandom_range(2) == 0);
            if (pop_mode == 2) rd[i] = 1'b1;
        end
        if ($urandom_range(29) == 0) st[$urandom_range(CH - 1)] = 1'b1;
        if (m_prev && !nr) st = '0;
        cycle(nr, st, rd);
    endtask

    initial begin
        int gap, low, pm;
        nRESET = 1'b0; nRFSH = 1'b1; ch_start = '0; ch_rd = '0; ch_base = '0; ch_len = '0;
        model_reset();
        repeat (3) @(posedge clk_sys);
        #1;
        chk("rst_mem_rd", {63'd0, mem_rd}, 64'd0);
        chk("rst_mem_addr", {39'd0, mem_addr}, 64'd0);
        chk("rst_empty", {62'd0, ch_empty}, 64'd3);
        chk("rst_busy", {62'd0, ch_busy}, 64'd0);
        chk("rst_dout", {48'd0, ch_dout}, 64'd0);
        nRESET = 1'b1;

        for (int s = 0; s < 350; s++) begin
            pm  = $urandom_range(2);
            gap = $urandom_range(1, 4);
            low = ($urandom_range(4) == 0) ? $urandom_range(1, AD - 2) : $urandom_range(AD, AD + 3);
            for (int c = 0; c < gap; c++) rand_cycle(1'b1, pm);
            for (int c = 0; c < low; c++) rand_cycle(1'b0, pm);
        end

        // Asynchronous reset in the middle of a fetch.
        ch_base[0 +: AW] = AW'(32'h2000);
        ch_len[0 +: AW]  = AW'(4);
        cycle(1'b1, 2'b01, 2'b00);
        cycle(1'b0, 2'b00, 2'b00);
        cycle(1'b0, 2'b00, 2'b00);
        chk("pre_rst_rd", {63'd0, mem_rd}, 64'd1);
        #2;
        nRESET = 1'b0;
        #1;
        chk("async_rst_rd", {63'd0, mem_rd}, 64'd0);
        chk("async_rst_empty", {62'd0, ch_empty}, 64'd3);
        chk("async_rst_busy", {62'd0, ch_busy}, 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
